// File: rtl/dispatch_pkg.sv
// dispatch_pkg: class codes, FSM encoding and MIPS opcode/funct/rt constants for dispatch_ctrl
package dispatch_pkg;
  typedef enum logic [1:0] {CLS_ALU = 2'd0, CLS_BR = 2'd1, CLS_MEM = 2'd2, CLS_MDU = 2'd3} cls_e;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_STALL = 2'd1, ST_FLUSH = 2'd2, ST_HALT = 2'd3} state_e;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_BREAK   = 6'h0d;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
endpackage

// File: rtl/dispatch_if.sv
// dispatch_if: fetch handshake, retire/release/flush inputs and status outputs of dispatch_ctrl
interface dispatch_if;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        instr_valid;
  logic        issue;
  logic [1:0]  issue_class;
  logic        rob_commit;
  logic [3:0]  rs_release;
  logic        flush;
  logic        halted;
  logic [63:0] cycle_count;
  logic [31:0] stall_count;
  modport master (
    output instr, addr, instr_valid, rob_commit, rs_release, flush,
    input  issue, issue_class, halted, cycle_count, stall_count
  );
  modport slave (
    input  instr, addr, instr_valid, rob_commit, rs_release, flush,
    output issue, issue_class, halted, cycle_count, stall_count
  );
endinterface

// File: rtl/dispatch_decode.sv
// dispatch_decode: combinational MIPS instruction to reservation-station class decode plus break detect
module dispatch_decode
  import dispatch_pkg::*;
(
  input  logic [31:0] instr,
  output cls_e        cls,
  output logic        is_break
);
  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic       sp;
  logic       br;
  logic       mem;
  logic       mdu;
  logic       unused_fields;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign unused_fields = ^{instr[25:21], instr[15:6]};
  // anything not recognised as BR/MEM/MDU falls through to ALU, break included
  always_comb begin
    sp       = op == OP_SPECIAL;
    br       = op == OP_BEQ || op == OP_BNE || op == OP_J || op == OP_JAL ||
               (op == OP_REGIMM && (rt == RT_BLTZ || rt == RT_BGEZ)) || (sp && fn == FN_JR);
    mem      = op == OP_LW || op == OP_SW;
    mdu      = sp && (fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU ||
                      fn == FN_MFHI || fn == FN_MFLO);
    is_break = sp && fn == FN_BREAK;
    cls      = br ? CLS_BR : mem ? CLS_MEM : mdu ? CLS_MDU : CLS_ALU;
  end
endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: in-order dispatch gate with ROB/RS occupancy tracking; DISPATCH_PERF_EN enables stall_count
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int ROB_DEPTH = 16,
  parameter int RS_DEPTH  = 4
) (
  input  logic      clk,
  input  logic      reset,
  dispatch_if.slave bus
);
  localparam int RW = $clog2(ROB_DEPTH + 1);
  localparam int SW = $clog2(RS_DEPTH + 1);
  localparam logic [RW-1:0] ROB_MAX = RW'(ROB_DEPTH);
  localparam logic [SW-1:0] RS_MAX  = SW'(RS_DEPTH);
  state_e        state_q, state_d;
  logic [RW-1:0] rob_cnt_q, rob_cnt_d;
  logic [SW-1:0] rs_cnt_q [4];
  logic [SW-1:0] rs_cnt_d [4];
  logic [63:0]   cycle_count_q, cycle_count_d;
  cls_e          cls;
  logic          is_break;
  logic          issue;
  logic          unused_addr;
  assign unused_addr = ^bus.addr;
  dispatch_decode u_decode (.instr(bus.instr), .cls(cls), .is_break(is_break));
  // accept only with room in both the ROB and the target RS class; held off during reset
  always_comb begin
    issue = !reset && (state_q == ST_RUN || state_q == ST_STALL) && bus.instr_valid &&
            !bus.flush && rob_cnt_q < ROB_MAX && rs_cnt_q[cls] < RS_MAX;
  end
  // flush wins from any state; HALT is sticky until flush or reset
  always_comb begin
    state_d = bus.flush               ? ST_FLUSH :
              state_q == ST_FLUSH     ? ST_RUN   :
              state_q == ST_HALT      ? ST_HALT  :
              (issue && is_break)     ? ST_HALT  :
              (bus.instr_valid && !issue) ? ST_STALL : ST_RUN;
  end
  // occupancy counters: decrements at zero are dropped, flush clears everything
  always_comb begin
    rob_cnt_d = bus.flush ? '0 :
                rob_cnt_q + RW'(issue) - RW'(bus.rob_commit && rob_cnt_q != '0);
    for (int k = 0; k < 4; k++)
      rs_cnt_d[k] = bus.flush ? '0 :
                    rs_cnt_q[k] + SW'(issue && cls == cls_e'(k)) - SW'(bus.rs_release[k] && rs_cnt_q[k] != '0);
    cycle_count_d = cycle_count_q + 64'd1;
  end
  // state and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      rob_cnt_q     <= '0;
      rs_cnt_q      <= '{default: '0};
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rob_cnt_q     <= rob_cnt_d;
      rs_cnt_q      <= rs_cnt_d;
      cycle_count_q <= cycle_count_d;
    end
  end
`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;
  // saturating count of cycles where a valid instruction was held back outside HALT
  always_comb begin
    stall_count_d = (bus.instr_valid && !issue && state_q != ST_HALT && stall_count_q != '1) ?
                    stall_count_q + 32'd1 : stall_count_q;
  end
  // stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end
  assign bus.stall_count = stall_count_q;
`else
  assign bus.stall_count = '0;
`endif
  assign bus.issue       = issue;
  assign bus.issue_class = cls;
  assign bus.halted      = state_q == ST_HALT;
  assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed self-checking bench for dispatch_ctrl
module tb_dispatch_ctrl;
  import dispatch_pkg::*;
  localparam logic [31:0] ADDIU = 32'h24010001;
  localparam logic [31:0] LW    = 32'h8c010000;
  localparam logic [31:0] BRK   = 32'h0000000d;
`ifdef DISPATCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  dispatch_if bus ();
  dispatch_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_flush;
    bus.instr_valid = 1'b0;
    bus.rob_commit  = 1'b0;
    bus.rs_release  = 4'b0;
    bus.flush       = 1'b1;
    tick;
    bus.flush = 1'b0;
    tick;
  endtask
  function automatic logic [63:0] stall_exp(input int n);
    return PERF ? 64'(n) : 64'd0;
  endfunction
  logic [31:0] dec_in  [17] = '{32'h10000000, 32'h14000000, 32'h04010000, 32'h04000000, 32'h08000000,
                                32'h0c000000, 32'h00000008, 32'hac000000, 32'h00000018, 32'h00000019,
                                32'h0000001a, 32'h0000001b, 32'h00000010, 32'h00000012, 32'h04020000,
                                32'hfc000000, 32'h00000020};
  logic [1:0]  dec_exp [17] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3,
                                2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
  initial begin
    int n;
    reset           = 1'b1;
    bus.instr       = ADDIU;
    bus.addr        = 32'h0000_1000;
    bus.instr_valid = 1'b1;
    bus.rob_commit  = 1'b0;
    bus.rs_release  = 4'b0;
    bus.flush       = 1'b0;
    #1;
    chk("rst_issue", 64'(bus.issue), 64'd0);
    tick;
    tick;
    chk("rst_cycle", bus.cycle_count, 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    chk("rst_stall", 64'(bus.stall_count), 64'd0);
    chk("rst_rob", 64'(dut.rob_cnt_q), 64'd0);
    reset           = 1'b0;
    bus.instr_valid = 1'b0;
    tick;
    // ROB fill: ALU RS drained every cycle so only the ROB limits
    bus.instr       = ADDIU;
    bus.instr_valid = 1'b1;
    bus.rs_release  = 4'b0001;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t1_issue", 64'(bus.issue), (i < 16) ? 64'd1 : 64'd0);
      if (i == 0) chk("t1_class", 64'(bus.issue_class), 64'd0);
      if (bus.issue) n++;
      tick;
    end
    chk("t1_count", 64'(n), 64'd16);
    chk("t1_rob", 64'(dut.rob_cnt_q), 64'd16);
    chk("t1_state", 64'(dut.state_q), 64'(ST_STALL));
    chk("t1_stall", 64'(bus.stall_count), stall_exp(4));
    bus.rob_commit  = 1'b1;
    bus.instr_valid = 1'b0;
    bus.flush       = 1'b1;
    tick;
    bus.flush      = 1'b0;
    bus.rob_commit = 1'b0;
    chk("t1_fl_state", 64'(dut.state_q), 64'(ST_FLUSH));
    chk("t1_fl_rob", 64'(dut.rob_cnt_q), 64'd0);
    tick;
    chk("t1_run", 64'(dut.state_q), 64'(ST_RUN));
    // MEM RS fill
    bus.instr       = LW;
    bus.instr_valid = 1'b1;
    bus.rs_release  = 4'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_issue", 64'(bus.issue), (i < 4) ? 64'd1 : 64'd0);
      if (bus.issue) chk("t2_class", 64'(bus.issue_class), 64'd2);
      if (bus.issue) n++;
      tick;
    end
    chk("t2_count", 64'(n), 64'd4);
    bus.rs_release = 4'b0100;
    #1;
    chk("t2_rel_cyc", 64'(bus.issue), 64'd0);
    tick;
    bus.rs_release = 4'b0;
    #1;
    chk("t2_fifth", 64'(bus.issue), 64'd1);
    chk("t2_fifth_cls", 64'(bus.issue_class), 64'd2);
    tick;
    chk("t2_rs_mem", 64'(dut.rs_cnt_q[2]), 64'd4);
    do_flush;
    // commit against a full ROB
    bus.instr       = ADDIU;
    bus.instr_valid = 1'b1;
    bus.rs_release  = 4'b0001;
    for (int i = 0; i < 16; i++) tick;
    chk("t3_full", 64'(dut.rob_cnt_q), 64'd16);
    bus.rob_commit = 1'b1;
    #1;
    chk("t3_blocked", 64'(bus.issue), 64'd0);
    tick;
    bus.rob_commit = 1'b0;
    #1;
    chk("t3_rob15", 64'(dut.rob_cnt_q), 64'd15);
    chk("t3_issue", 64'(bus.issue), 64'd1);
    tick;
    chk("t3_rob16", 64'(dut.rob_cnt_q), 64'd16);
    do_flush;
    // class decode, counters kept near empty
    bus.instr_valid = 1'b1;
    bus.rob_commit  = 1'b1;
    bus.rs_release  = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      bus.instr = dec_in[i];
      #1;
      chk("dec_issue", 64'(bus.issue), 64'd1);
      chk("dec_class", 64'(bus.issue_class), 64'(dec_exp[i]));
      tick;
    end
    do_flush;
    // break -> HALT -> flush -> RUN
    bus.instr       = BRK;
    bus.instr_valid = 1'b1;
    #1;
    chk("t4_brk_issue", 64'(bus.issue), 64'd1);
    chk("t4_brk_class", 64'(bus.issue_class), 64'd0);
    tick;
    bus.instr = ADDIU;
    #1;
    chk("t4_halted", 64'(bus.halted), 64'd1);
    chk("t4_no_issue", 64'(bus.issue), 64'd0);
    tick;
    #1;
    chk("t4_no_issue2", 64'(bus.issue), 64'd0);
    chk("t4_stall_hold", 64'(bus.stall_count), stall_exp(7));
    bus.flush = 1'b1;
    #1;
    chk("t4_fl_issue", 64'(bus.issue), 64'd0);
    tick;
    bus.flush = 1'b0;
    #1;
    chk("t4_fl_state", 64'(dut.state_q), 64'(ST_FLUSH));
    chk("t4_fl_issue2", 64'(bus.issue), 64'd0);
    chk("t4_fl_halted", 64'(bus.halted), 64'd0);
    chk("t4_fl_rob", 64'(dut.rob_cnt_q), 64'd0);
    chk("t4_fl_rs", 64'(dut.rs_cnt_q[0]) + 64'(dut.rs_cnt_q[1]) + 64'(dut.rs_cnt_q[2]) + 64'(dut.rs_cnt_q[3]), 64'd0);
    tick;
    chk("t4_run", 64'(dut.state_q), 64'(ST_RUN));
    chk("t4_resume", 64'(bus.issue), 64'd1);
    do_flush;
    // reset mid-stall at cycle_count 0x20
    reset = 1'b1;
    tick;
    reset           = 1'b0;
    bus.instr       = ADDIU;
    bus.instr_valid = 1'b1;
    bus.rs_release  = 4'b0001;
    n = 0;
    while (bus.cycle_count != 64'h20 && n < 200) begin
      tick;
      n++;
    end
    chk("t5_reach", bus.cycle_count, 64'h20);
    chk("t5_stalled", 64'(dut.state_q), 64'(ST_STALL));
    reset = 1'b1;
    #1;
    chk("t5_rst_issue", 64'(bus.issue), 64'd0);
    chk("t5_rst_cycle", bus.cycle_count, 64'd0);
    tick;
    reset = 1'b0;
    #1;
    chk("t5_cycle", bus.cycle_count, 64'd0);
    chk("t5_rob", 64'(dut.rob_cnt_q), 64'd0);
    chk("t5_stall", 64'(bus.stall_count), 64'd0);
    chk("t5_issue", 64'(bus.issue), 64'd1);
    tick;
    chk("t5_cycle1", bus.cycle_count, 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 Parameter ROB_DEPTH, default 16, SHALL set reorder-buffer entry count (power of 2, 4..64).
REQ-002 Parameter RS_DEPTH, default 4, SHALL set the entry count of each reservation-station class.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 instr  in  32  MIPS instruction presented for dispatch.
REQ-006 addr  in  32  PC of instr.
REQ-007 instr_valid  in  1  instr/addr valid this cycle.
REQ-008 issue  out  1  instr accepted into ROB this cycle; doubles as fetch acknowledge and tracer issue strobe.
REQ-009 issue_class  out  2  class of instr: 0 ALU, 1 BR, 2 MEM, 3 MDU; valid when issue=1.
REQ-010 rob_commit  in  1  one ROB entry retired this cycle.
REQ-011 rs_release  in  4  one-hot per class; bit k frees one class-k RS entry.
REQ-012 flush  in  1  mispredict/exception flush of ROB and all RS.
REQ-013 halted  out  1  HALT state.
REQ-014 cycle_count  out  64  free-running cycle counter.
REQ-015 stall_count  out  32  dispatch-stall cycle counter (see Configuration).

Function
REQ-016 Class decode: beq, bne, bgez, bltz, j, jal, jr -> BR; lw, sw -> MEM; mult, multu, div, divu, mfhi, mflo -> MDU; all other opcodes/functs, including break and unknown encodings -> ALU.
REQ-017 FSM states RUN, STALL, FLUSH, HALT; reset state RUN.
REQ-018 issue SHALL be combinational: state in {RUN, STALL} & instr_valid & !flush & rob_cnt<ROB_DEPTH & rs_cnt[class]<RS_DEPTH; zero-cycle latency.
REQ-019 RUN/STALL -> STALL when instr_valid & !issue & !flush; -> RUN when issue or !instr_valid.
REQ-020 Any state with flush=1 -> FLUSH; FLUSH -> RUN after exactly one cycle; issue=0 in FLUSH.
REQ-021 Issued break (op 0, funct 0x0D) -> HALT next cycle; HALT exits only via flush or reset; issue=0 in HALT.
REQ-022 rob_cnt (0..ROB_DEPTH) += issue, -= rob_commit; simultaneous issue and commit SHALL leave rob_cnt unchanged.
REQ-023 rs_cnt[k] (0..RS_DEPTH) += issue&(class==k), -= rs_release[k]; simultaneous increment and decrement cancel.
REQ-024 Decrement at count 0 SHALL be ignored (no underflow); count never exceeds its depth.
REQ-025 flush SHALL zero rob_cnt and all rs_cnt on the next edge, overriding same-cycle commit/release.
REQ-026 cycle_count SHALL increment every cycle, wrapping 2^64-1 -> 0.

Reset
REQ-027 reset SHALL force, asynchronously: state RUN, rob_cnt 0, all rs_cnt 0, cycle_count 0, stall_count 0, halted 0; issue 0 while reset asserted.
REQ-028 reset mid-stall or mid-HALT SHALL discard all pending state; no issue before first post-reset edge.

Configuration
REQ-029 With DISPATCH_PERF_EN defined, stall_count SHALL increment (saturating at 2^32-1) each cycle with instr_valid=1, issue=0 and state != HALT.
REQ-030 Without DISPATCH_PERF_EN, stall_count SHALL be constant 0 and no counter logic instantiated.

Structure
REQ-031 Package dispatch_pkg SHALL hold class codes, FSM state encoding, and opcode/funct/rt constants.
REQ-032 Class decode SHALL be sub-module dispatch_decode (combinational, instr -> class, is_break); counters and FSM stay in dispatch_ctrl.

Verification
REQ-033 Reset, 20 valid addiu (0x24010001), no commits, ROB_DEPTH 16 -> 16 issues, then issue=0, state STALL, stall_count increments (PERF on).
REQ-034 Five lw back-to-back, RS_DEPTH 4 -> 4 issues class 2; pulse rs_release=4'b0100 -> 5th issues next cycle.
REQ-035 rob_cnt 16, same cycle rob_commit=1 and valid instr -> no issue that cycle; next cycle issue=1, rob_cnt back to 16.
REQ-036 Issue break (0x0000000D) -> halted=1 next cycle; further valid instrs not issued; flush -> FLUSH one cycle, then RUN, all counts 0.
REQ-037 Assert reset for 1 cycle mid-STALL at cycle_count 0x20 -> cycle_count 0, counts 0, issue resumes first cycle after deassertion.
